// File: rtl/ecc_pm_seq_checker_if.sv
// rtl/ecc_pm_seq_checker_if.sv - operand/result bus between the sequencer and the point-multiplier
interface ecc_pm_seq_checker_if #(
   parameter int DATA_WIDTH = 192
);
   logic                  dut_in_valid;
   logic [DATA_WIDTH-1:0] dut_Px;
   logic [DATA_WIDTH-1:0] dut_Py;
   logic [DATA_WIDTH-1:0] dut_k;
   logic                  dut_out_valid;
   logic [DATA_WIDTH-1:0] dut_Rx;
   logic [DATA_WIDTH-1:0] dut_Ry;

   modport master (
      output dut_in_valid, dut_Px, dut_Py, dut_k,
      input  dut_out_valid, dut_Rx, dut_Ry
   );

   modport slave (
      input  dut_in_valid, dut_Px, dut_Py, dut_k,
      output dut_out_valid, dut_Rx, dut_Ry
   );
endinterface

// File: rtl/ecc_pm_seq_checker.sv
// rtl/ecc_pm_seq_checker.sv - pattern store, sequencer and result checker for the ECC point-multiplier
// Define ECC_PM_TIMEOUT_EN to bound each WAIT to TIMEOUT_CYCLES cycles.
module ecc_pm_seq_checker #(
   parameter int DATA_WIDTH     = 192,
   parameter int DEPTH          = 32,
   parameter int TIMEOUT_CYCLES = 1000000,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_we,
   input  logic [AW-1:0]         cfg_addr,
   input  logic [2:0]            cfg_field,
   input  logic [DATA_WIDTH-1:0] cfg_wdata,
   input  logic                  start,
   input  logic [CW-1:0]         num_pat,
   input  logic                  stop_on_fail,
   output logic                  busy,
   output logic                  done,
   output logic [CW-1:0]         pass_cnt,
   output logic [CW-1:0]         fail_cnt,
   output logic                  first_fail_vld,
   output logic [AW-1:0]         first_fail_idx,
   output logic                  proto_err,
   output logic                  timeout,
   ecc_pm_seq_checker_if.master  pm
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_DONE} state_t;

   state_t state, next_state;

   logic [DATA_WIDTH-1:0] px_mem [DEPTH];
   logic [DATA_WIDTH-1:0] py_mem [DEPTH];
   logic [DATA_WIDTH-1:0] k_mem  [DEPTH];
   logic [DATA_WIDTH-1:0] rx_mem [DEPTH];
   logic [DATA_WIDTH-1:0] ry_mem [DEPTH];

   logic [AW-1:0] idx;
   logic [CW-1:0] n_q;
   logic          stop_q;
   logic [CW-1:0] n_eff;
   logic          accept;
   logic          check;
   logic          fail_hit;
   logic          last;
   logic          match;
   logic          expire;

   // Store is deliberately outside the reset domain so patterns survive a run abort.
   always_ff @(posedge clk) begin
      if (cfg_we && !busy && (32'(cfg_addr) < DEPTH)) begin
         case (cfg_field)
            3'd0:    px_mem[cfg_addr] <= cfg_wdata;
            3'd1:    py_mem[cfg_addr] <= cfg_wdata;
            3'd2:    k_mem[cfg_addr]  <= cfg_wdata;
            3'd3:    rx_mem[cfg_addr] <= cfg_wdata;
            3'd4:    ry_mem[cfg_addr] <= cfg_wdata;
            default: ;
         endcase
      end
   end

   assign n_eff = (num_pat > CW'(DEPTH)) ? CW'(DEPTH) : num_pat;
   assign last  = ((CW'(idx) + CW'(1)) == n_q);
   assign match = (pm.dut_Rx == rx_mem[idx]) && (pm.dut_Ry == ry_mem[idx]);

   assign pm.dut_in_valid = (state == S_ISSUE);
   assign pm.dut_Px       = (state == S_ISSUE) ? px_mem[idx] : '0;
   assign pm.dut_Py       = (state == S_ISSUE) ? py_mem[idx] : '0;
   assign pm.dut_k        = (state == S_ISSUE) ? k_mem[idx]  : '0;

`ifdef ECC_PM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] wait_cnt;

   // Expiry fires on the TIMEOUT_CYCLES-th WAIT cycle; a response in that same cycle still wins.
   assign expire = (state == S_WAIT) && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         if (state == S_ISSUE)
            wait_cnt <= '0;
         else if (state == S_WAIT)
            wait_cnt <= wait_cnt + TW'(1);
         if (accept)
            timeout <= 1'b0;
         if (check && !pm.dut_out_valid)
            timeout <= 1'b1;
      end
   end
`else
   assign expire  = 1'b0;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      check      = 1'b0;
      fail_hit   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept     = 1'b1;
               next_state = (n_eff == '0) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: next_state = S_WAIT;
         S_WAIT: begin
            if (pm.dut_out_valid || expire) begin
               check      = 1'b1;
               fail_hit   = !(pm.dut_out_valid && match);
               next_state = (last || (fail_hit && stop_q)) ? S_DONE : S_GAP;
            end
         end
         S_GAP:   next_state = S_ISSUE;
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy           <= 1'b0;
         done           <= 1'b0;
         pass_cnt       <= '0;
         fail_cnt       <= '0;
         first_fail_vld <= 1'b0;
         first_fail_idx <= '0;
         proto_err      <= 1'b0;
         n_q            <= '0;
         stop_q         <= 1'b0;
         idx            <= '0;
      end else begin
         busy <= (next_state == S_ISSUE) || (next_state == S_WAIT) || (next_state == S_GAP);
         if (accept) begin
            n_q            <= n_eff;
            stop_q         <= stop_on_fail;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
            proto_err      <= 1'b0;
            done           <= 1'b0;
            idx            <= '0;
         end
         if (next_state == S_DONE)
            done <= 1'b1;
         if (check) begin
            if (fail_hit) begin
               fail_cnt <= fail_cnt + CW'(1);
               if (!first_fail_vld) begin
                  first_fail_vld <= 1'b1;
                  first_fail_idx <= idx;
               end
            end else begin
               pass_cnt <= pass_cnt + CW'(1);
            end
            if (next_state == S_GAP)
               idx <= idx + AW'(1);
         end
         // A stray result outside WAIT is flagged even in the cycle a new run is accepted.
         if (pm.dut_out_valid && (state != S_WAIT))
            proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ecc_pm_seq_checker.sv
// tb/tb_ecc_pm_seq_checker.sv - self-checking bench for ecc_pm_seq_checker with a stand-in point-multiplier
module tb_ecc_pm_seq_checker;
   localparam int DW    = 64;
   localparam int DEPTH = 4;
   localparam int TOC   = 16;
   localparam int AW    = 2;
   localparam int CW    = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_we = 1'b0;
   logic [AW-1:0] cfg_addr = '0;
   logic [2:0]    cfg_field = '0;
   logic [DW-1:0] cfg_wdata = '0;
   logic          start = 1'b0;
   logic [CW-1:0] num_pat = '0;
   logic          stop_on_fail = 1'b0;
   logic          busy, done, first_fail_vld, proto_err, timeout;
   logic [CW-1:0] pass_cnt, fail_cnt;
   logic [AW-1:0] first_fail_idx;

   ecc_pm_seq_checker_if #(.DATA_WIDTH(DW)) bus ();

   ecc_pm_seq_checker #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TOC)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_field(cfg_field),
      .cfg_wdata(cfg_wdata), .start(start), .num_pat(num_pat), .stop_on_fail(stop_on_fail),
      .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
      .first_fail_vld(first_fail_vld), .first_fail_idx(first_fail_idx),
      .proto_err(proto_err), .timeout(timeout), .pm(bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in multiplier: R = (Px ^ k, Py + k) after a programmable latency.
   int lat = 5;
   int in_pulses = 0;
   int mute_pulse = -1;
   int stray_req = 0;
   int stray_done = 0;
   int op_leak = 0;
   int issue_cyc[$];

   function automatic logic [DW-1:0] f_rx(input logic [DW-1:0] px, input logic [DW-1:0] k);
      return px ^ k;
   endfunction

   function automatic logic [DW-1:0] f_ry(input logic [DW-1:0] py, input logic [DW-1:0] k);
      return py + k;
   endfunction

   initial begin
      logic [DW-1:0] rsp_x, rsp_y;
      int rcnt;
      bit pend;
      pend = 1'b0;
      rcnt = 0;
      bus.dut_out_valid = 1'b0;
      bus.dut_Rx = '0;
      bus.dut_Ry = '0;
      forever begin
         @(negedge clk);
         bus.dut_out_valid = 1'b0;
         if (stray_done < stray_req) begin
            bus.dut_out_valid = 1'b1;
            stray_done++;
         end
         if (bus.dut_in_valid === 1'b1) begin
            rsp_x = f_rx(bus.dut_Px, bus.dut_k);
            rsp_y = f_ry(bus.dut_Py, bus.dut_k);
            pend  = (in_pulses != mute_pulse);
            rcnt  = lat;
            issue_cyc.push_back(cyc);
            in_pulses++;
         end else begin
            if ((bus.dut_Px | bus.dut_Py | bus.dut_k) != '0) op_leak++;
            if (pend) begin
               rcnt--;
               if (rcnt == 0) begin
                  bus.dut_out_valid = 1'b1;
                  bus.dut_Rx = rsp_x;
                  bus.dut_Ry = rsp_y;
                  pend = 1'b0;
               end
            end
         end
      end
   end

   logic [DW-1:0] m_px [DEPTH];
   logic [DW-1:0] m_py [DEPTH];
   logic [DW-1:0] m_k  [DEPTH];
   logic [DW-1:0] m_rx [DEPTH];
   logic [DW-1:0] m_ry [DEPTH];
   int last_q0 = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Expected outcome of a run, walked pattern by pattern over the bench's copy of the store.
   function automatic void model(input int np, input bit stop, input int mute,
                                 output int ep, output int ef, output int effv,
                                 output int effi, output int epul);
      int n;
      bit ok;
      n = (np > DEPTH) ? DEPTH : np;
      ep = 0; ef = 0; effv = 0; effi = 0; epul = 0;
      for (int i = 0; i < n; i++) begin
         epul++;
         ok = (mute != i) && (f_rx(m_px[i], m_k[i]) == m_rx[i]) && (f_ry(m_py[i], m_k[i]) == m_ry[i]);
         if (ok) ep++;
         else begin
            ef++;
            if (effv == 0) begin effv = 1; effi = i; end
            if (stop) break;
         end
      end
   endfunction

   task automatic cfg_write(input int addr, input int field, input logic [DW-1:0] data);
      cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_field = 3'(field); cfg_wdata = data;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic load_slot(input int i, input int corrupt);
      m_px[i] = {$urandom, $urandom};
      m_py[i] = {$urandom, $urandom};
      m_k[i]  = {$urandom, $urandom};
      m_rx[i] = f_rx(m_px[i], m_k[i]);
      m_ry[i] = f_ry(m_py[i], m_k[i]);
      if (corrupt == 1) m_rx[i] = m_rx[i] ^ (64'd1 << $urandom_range(0, DW - 1));
      if (corrupt == 2) m_ry[i] = m_ry[i] ^ (64'd1 << $urandom_range(0, DW - 1));
      cfg_write(i, 0, m_px[i]);
      cfg_write(i, 1, m_py[i]);
      cfg_write(i, 2, m_k[i]);
      cfg_write(i, 3, m_rx[i]);
      cfg_write(i, 4, m_ry[i]);
   endtask

   task automatic do_run(input string tag, input int np, input bit stop, input int mute,
                         input bit co_we, input int co_addr, input int co_field,
                         input logic [DW-1:0] co_data, input bit busy_wr);
      int ep, ef, effv, effi, epul, p0, n;
      model(np, stop, mute, ep, ef, effv, effi, epul);
      p0 = in_pulses;
      last_q0 = issue_cyc.size();
      mute_pulse = (mute >= 0) ? in_pulses + mute : -1;
      start = 1'b1; num_pat = CW'(np); stop_on_fail = stop;
      cfg_we = co_we; cfg_addr = AW'(co_addr); cfg_field = 3'(co_field); cfg_wdata = co_data;
      @(negedge clk);
      start = 1'b0; cfg_we = 1'b0;
      if (np > 0) chk({tag, ".done_clr"}, done, 0);
      if (busy_wr) begin
         cfg_write($urandom_range(0, DEPTH - 1), $urandom_range(0, 4), {$urandom, $urandom});
      end
      n = 0;
      while (!done && n < 600) begin
         @(negedge clk);
         n++;
      end
      chk({tag, ".done"}, done, 1);
      chk({tag, ".busy"}, busy, 0);
      chk({tag, ".pass"}, pass_cnt, ep);
      chk({tag, ".fail"}, fail_cnt, ef);
      chk({tag, ".ffv"}, first_fail_vld, effv);
      chk({tag, ".ffi"}, first_fail_idx, effi);
      chk({tag, ".pulses"}, in_pulses - p0, epul);
      chk({tag, ".proto"}, proto_err, 0);
`ifdef ECC_PM_TIMEOUT_EN
      chk({tag, ".timeout"}, timeout, (mute >= 0 && mute < epul) ? 1 : 0);
`else
      chk({tag, ".timeout"}, timeout, 0);
`endif
      mute_pulse = -1;
      @(negedge clk);
   endtask

   initial begin
      int p0, gap;
      logic [DW-1:0] fix;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.pass", pass_cnt, 0);
      chk("rst.fail", fail_cnt, 0);
      chk("rst.ffv", first_fail_vld, 0);
      chk("rst.ffi", first_fail_idx, 0);
      chk("rst.proto", proto_err, 0);
      chk("rst.timeout", timeout, 0);
      chk("rst.in_valid", bus.dut_in_valid, 0);
      chk("rst.px", bus.dut_Px, 0);

      for (int i = 0; i < DEPTH; i++) load_slot(i, 0);
      lat = 5;
      do_run("basic", 3, 1'b0, -1, 1'b0, 0, 0, '0, 1'b0);
      for (int j = 1; j < 3; j++) begin
         gap = (issue_cyc.size() > last_q0 + j) ? issue_cyc[last_q0 + j] - issue_cyc[last_q0 + j - 1] : -1;
         chk($sformatf("basic.spacing%0d", j), gap, 7);
      end

      m_rx[1] = m_rx[1] ^ 64'd1;
      cfg_write(1, 3, m_rx[1]);
      lat = $urandom_range(1, 6);
      do_run("corrupt", 3, 1'b0, -1, 1'b0, 0, 0, '0, 1'b0);
      chk("corrupt.ffi_abs", first_fail_idx, 1);
      lat = $urandom_range(1, 6);
      do_run("stop", 3, 1'b1, -1, 1'b0, 0, 0, '0, 1'b0);
      chk("stop.fail_abs", fail_cnt, 1);

      p0 = in_pulses;
      start = 1'b1; num_pat = '0; stop_on_fail = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("zero.done", done, 1);
      chk("zero.busy", busy, 0);
      chk("zero.pass", pass_cnt, 0);
      chk("zero.fail", fail_cnt, 0);
      repeat (3) @(negedge clk);
      chk("zero.pulses", in_pulses - p0, 0);

      lat = 1;
      do_run("clamp", 7, 1'b0, -1, 1'b0, 0, 0, '0, 1'b0);
      lat = $urandom_range(2, 6);
      do_run("busy_wr", 4, 1'b0, -1, 1'b0, 0, 0, '0, 1'b1);
      for (int f = 5; f < 8; f++) cfg_write($urandom_range(0, DEPTH - 1), f, {$urandom, $urandom});
      do_run("bad_field", 4, 1'b0, -1, 1'b0, 0, 0, '0, 1'b0);

      fix = {$urandom, $urandom};
      m_px[0] = fix;
      do_run("co_write", 4, 1'b0, -1, 1'b1, 0, 0, fix, 1'b0);

      stray_req++;
      repeat (2) @(negedge clk);
      chk("stray.proto", proto_err, 1);
      lat = 5;
      start = 1'b1; num_pat = CW'(3); stop_on_fail = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort.busy", busy, 0);
      chk("abort.done", done, 0);
      chk("abort.pass", pass_cnt, 0);
      chk("abort.fail", fail_cnt, 0);
      chk("abort.proto", proto_err, 0);
      repeat (6) @(negedge clk);
      chk("abort.late_proto", proto_err, 1);
      do_run("rerun", 4, 1'b0, -1, 1'b0, 0, 0, '0, 1'b0);

      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < DEPTH; i++) load_slot(i, $urandom_range(0, 2));
         lat = $urandom_range(1, 8);
         do_run($sformatf("rnd%0d", it), $urandom_range(0, 7), 1'($urandom_range(0, 1)), -1,
                1'b0, 0, 0, '0, 1'b0);
      end

`ifdef ECC_PM_TIMEOUT_EN
      for (int i = 0; i < DEPTH; i++) load_slot(i, 0);
      lat = 3;
      do_run("tmo", 2, 1'b0, 0, 1'b0, 0, 0, '0, 1'b0);
      gap = (issue_cyc.size() > last_q0 + 1) ? issue_cyc[last_q0 + 1] - issue_cyc[last_q0] : -1;
      chk("tmo.reissue", gap, TOC + 2);
      chk("tmo.ffi_abs", first_fail_idx, 0);
`endif

      chk("op_leak", op_leak, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
